alu_power_controller: RTL and testbench

- Sequencing controller in front of the ALU and its clock scaler.
- Measures ALU demand over fixed windows and selects the Power_Mode code driven to the scaler (00 = /4, 01 = /2, 10 = full).
- Gates the ALU clock enable after an idle timeout.
- Blanks the enable for a settle period around every mode change, with a valid/ready handshake to the requester.

---
 rtl/alu_power_controller.sv | 164 ++++++++++++++++
 tb/tb_alu_power_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_power_controller.sv
// Power sequencing in front of the ALU: windowed demand measurement selects the
// clock-scaler mode, idle timeout gates the ALU clock, and mode changes blank the enable.
module alu_power_controller #(
  parameter int WIN_LEN      = 64,
  parameter int HI_TH        = 48,
  parameter int LO_TH        = 16,
  parameter int IDLE_TIMEOUT = 8,
  parameter int SETTLE       = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Op_Valid,
  output logic       Op_Ready,
  input  logic       Mode_Override_En,
  input  logic [1:0] Mode_Override,
  output logic [1:0] Power_Mode,
  output logic       Clk_En,
  output logic       Mode_Change,
  output logic [1:0] Dbg_State
);

  localparam int WIN_W  = $clog2(WIN_LEN);
  localparam int DEM_W  = $clog2(WIN_LEN + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [DEM_W-1:0]  DEM_MAX   = DEM_W'(WIN_LEN);
  localparam logic [DEM_W-1:0]  HI_TH_C   = DEM_W'(HI_TH);
  localparam logic [DEM_W-1:0]  LO_TH_C   = DEM_W'(LO_TH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_GATED  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        power_mode_q, power_mode_d;
  logic              clk_en_q, clk_en_d;
  logic              op_ready_q, op_ready_d;
  logic              mode_change_q, mode_change_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [DEM_W-1:0]  dem_cnt_q, dem_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [1:0]        pend_q, pend_d;

  logic [1:0]       ov_mode;
  logic [1:0]       target;
  logic [1:0]       new_mode;
  logic [DEM_W-1:0] dem_inc;
  logic             win_end, decide, ov_commit, win_commit, commit;

  always_comb begin
    ov_mode    = (Mode_Override == 2'b11) ? 2'b10 : Mode_Override;
    win_end    = (win_cnt_q == WIN_LAST);
    // The closing cycle's own request belongs to the window being judged.
    dem_inc    = (Op_Valid && (dem_cnt_q != DEM_MAX)) ? dem_cnt_q + 1'b1 : dem_cnt_q;
    target     = (dem_inc >= HI_TH_C) ? 2'b10 : ((dem_inc >= LO_TH_C) ? 2'b01 : 2'b00);
    decide     = win_end && (state_q != ST_SWITCH) && !Mode_Override_En;
    ov_commit  = Mode_Override_En && (state_q != ST_SWITCH) && (ov_mode != power_mode_q);
    win_commit = decide && (target != power_mode_q) && pend_vld_q && (pend_q == target);
    commit     = ov_commit || win_commit;
    new_mode   = ov_commit ? ov_mode : target;

    state_d       = state_q;
    power_mode_d  = power_mode_q;
    mode_change_d = 1'b0;
    idle_cnt_d    = idle_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    pend_vld_d    = pend_vld_q;
    pend_d        = pend_q;
    win_cnt_d     = win_end ? '0 : win_cnt_q + 1'b1;
    dem_cnt_d     = win_end ? '0 : dem_inc;

    if (win_end) begin
      if (!decide || (target == power_mode_q) || win_commit) begin
        pend_vld_d = 1'b0;
        pend_d     = 2'b00;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = target;
      end
    end

    // A commit preempts both idle gating and wake-up.
    if (commit) begin
      state_d       = ST_SWITCH;
      power_mode_d  = new_mode;
      mode_change_d = 1'b1;
      settle_cnt_d  = SET_LAST;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Op_Valid) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q >= IDLE_LAST) begin
            state_d    = ST_GATED;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        ST_GATED: begin
          if (Op_Valid) begin
            state_d    = ST_RUN;
            idle_cnt_d = '0;
          end
        end
        ST_SWITCH: begin
          if (settle_cnt_q == '0) begin
            state_d    = ST_RUN;
            idle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    clk_en_d   = (state_d == ST_RUN);
    op_ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_RUN;
      power_mode_q  <= 2'b10;
      clk_en_q      <= 1'b1;
      op_ready_q    <= 1'b1;
      mode_change_q <= 1'b0;
      win_cnt_q     <= '0;
      dem_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      pend_vld_q    <= 1'b0;
      pend_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      power_mode_q  <= power_mode_d;
      clk_en_q      <= clk_en_d;
      op_ready_q    <= op_ready_d;
      mode_change_q <= mode_change_d;
      win_cnt_q     <= win_cnt_d;
      dem_cnt_q     <= dem_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_q        <= pend_d;
    end
  end

  assign Op_Ready    = op_ready_q;
  assign Power_Mode  = power_mode_q;
  assign Clk_En      = clk_en_q;
  assign Mode_Change = mode_change_q;
  assign Dbg_State   = state_q;

endmodule

// File: tb/tb_alu_power_controller.sv
// Directed bench for alu_power_controller: gating, hysteresis, override, handshake
// blanking and asynchronous reset, all with hand-computed expectations.
module tb_alu_power_controller;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_GATED  = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic       ovr_en;
  logic [1:0] ovr;
  logic [1:0] power_mode;
  logic       clk_en;
  logic       mode_change;
  logic [1:0] dbg_state;

  int n_checks;
  int n_pass;
  int cyc;
  logic mc_seen;

  alu_power_controller dut (
    .Clk              (clk),
    .Rst_n            (rst_n),
    .Op_Valid         (op_valid),
    .Op_Ready         (op_ready),
    .Mode_Override_En (ovr_en),
    .Mode_Override    (ovr),
    .Power_Mode       (power_mode),
    .Clk_En           (clk_en),
    .Mode_Change      (mode_change),
    .Dbg_State        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n    = 1'b0;
    op_valid = 1'b0;
    ovr_en   = 1'b0;
    ovr      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    mc_seen = mc_seen | mode_change;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v)
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    else
      n_pass = n_pass + 1;
  endtask

  // One 64-cycle window with op_valid high on its first n_high cycles.
  task automatic run_window(input int n_high);
    for (int i = 0; i < 64; i++) begin
      op_valid = (i < n_high);
      tick();
    end
    op_valid = 1'b0;
  endtask

  task automatic run_to(input int last_cyc);
    while (cyc < last_cyc) tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mc_seen  = 1'b0;

    // 1: reset values, idle gating after 8 cycles, 1-cycle wake-up
    do_reset();
    check("rst_mode",   8'(power_mode), 8'h2);
    check("rst_clk_en", 8'(clk_en), 8'h1);
    check("rst_ready",  8'(op_ready), 8'h1);
    check("rst_mc",     8'(mode_change), 8'h0);
    check("rst_state",  8'(dbg_state), 8'(S_RUN));
    repeat (7) tick();
    check("idle7_clk_en", 8'(clk_en), 8'h1);
    tick();
    check("idle8_clk_en", 8'(clk_en), 8'h0);
    check("idle8_ready",  8'(op_ready), 8'h0);
    check("idle8_state",  8'(dbg_state), 8'(S_GATED));
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    check("wake_clk_en", 8'(clk_en), 8'h1);
    check("wake_ready",  8'(op_ready), 8'h1);

    // 2: two low-demand windows -> commit to /4 with a 4-cycle blank
    do_reset();
    mc_seen = 1'b0;
    run_window(10);
    check("w1_mode", 8'(power_mode), 8'h2);
    check("w1_mc",   8'(mc_seen), 8'h0);
    run_window(10);
    check("w2_mode",   8'(power_mode), 8'h0);
    check("w2_mc",     8'(mode_change), 8'h1);
    check("w2_clk_en", 8'(clk_en), 8'h0);
    check("w2_state",  8'(dbg_state), 8'(S_SWITCH));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("settle_clk_en", 8'(clk_en), 8'h0);
      check("settle_mc",     8'(mode_change), 8'h0);
    end
    tick();
    check("post_settle_clk_en", 8'(clk_en), 8'h1);
    check("post_settle_state",  8'(dbg_state), 8'(S_RUN));

    // 4: override from GATED at /4, window decisions ignored while held
    repeat (8) tick();
    check("ov_pre_state", 8'(dbg_state), 8'(S_GATED));
    ovr_en = 1'b1;
    ovr    = 2'b11;
    tick();
    check("ov_state", 8'(dbg_state), 8'(S_SWITCH));
    check("ov_mode",  8'(power_mode), 8'h2);
    check("ov_mc",    8'(mode_change), 8'h1);
    mc_seen = 1'b0;
    run_to(260);
    check("ov_hold_mode", 8'(power_mode), 8'h2);
    check("ov_hold_mc",   8'(mc_seen), 8'h0);
    ovr_en = 1'b0;
    ovr    = 2'b00;
    run_to(320);
    check("ov_rel_first_win_mode", 8'(power_mode), 8'h2);
    run_to(384);
    check("ov_rel_second_win_mode", 8'(power_mode), 8'h0);
    check("ov_rel_second_win_mc",   8'(mode_change), 8'h1);

    // 3: alternating 30/50 windows never confirm a pending target
    do_reset();
    mc_seen = 1'b0;
    run_window(30);
    check("alt1_mode", 8'(power_mode), 8'h2);
    run_window(50);
    check("alt2_mode", 8'(power_mode), 8'h2);
    run_window(30);
    check("alt3_mode", 8'(power_mode), 8'h2);
    run_window(50);
    check("alt4_mode", 8'(power_mode), 8'h2);
    check("alt_mc",    8'(mc_seen), 8'h0);

    // 5: op held across a commit is blocked through SWITCH, accepted on first RUN
    do_reset();
    op_valid = 1'b1;
    ovr_en   = 1'b1;
    ovr      = 2'b01;
    check("hs_pre_ready", 8'(op_ready), 8'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hs_switch_ready", 8'(op_ready), 8'h0);
    end
    check("hs_mode", 8'(power_mode), 8'h1);
    tick();
    check("hs_run_ready", 8'(op_ready), 8'h1);
    check("hs_run_valid", 8'(op_valid), 8'h1);
    op_valid = 1'b0;
    ovr_en   = 1'b0;
    ovr      = 2'b00;
    tick();
    check("hs_no_recommit_mode", 8'(power_mode), 8'h1);

    // 6: asynchronous reset during the second SWITCH cycle
    do_reset();
    ovr_en = 1'b1;
    ovr    = 2'b00;
    tick();
    check("ar_mc", 8'(mode_change), 8'h1);
    tick();
    check("ar_state", 8'(dbg_state), 8'(S_SWITCH));
    ovr_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("ar_mode",   8'(power_mode), 8'h2);
    check("ar_clk_en", 8'(clk_en), 8'h1);
    check("ar_mc0",    8'(mode_change), 8'h0);
    check("ar_ready",  8'(op_ready), 8'h1);
    check("ar_state0", 8'(dbg_state), 8'(S_RUN));
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    repeat (7) tick();
    check("ar_idle7_clk_en", 8'(clk_en), 8'h1);
    tick();
    check("ar_idle8_clk_en", 8'(clk_en), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
